// File: rtl/consulta_linha_pkg.sv
// Shared line layout for the time-windowed bloom table: field positions, sizes
// and extraction helpers used by both the query engine and the line-update path.
package consulta_linha_pkg;

    localparam int DATA_WIDTH      = 72;
    localparam int NUM_BUCKETS     = 14;
    localparam int BUCKET_SZ       = 4;
    localparam int BITS_SHIFT      = 4;
    localparam int BLOOM_INIT_POS  = 16;
    localparam int LOOP_W          = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int SRAM_ADDR_WIDTH = 19;
    localparam int COUNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EVAL = 2'd2,
        ST_RESP = 2'd3
    } estado_t;

    typedef logic [DATA_WIDTH-1:0] linha_t;

    function automatic logic [LOOP_W-1:0] stamp_loop(input linha_t l);
        return l[LOOP_W-1:0];
    endfunction

    function automatic logic [BITS_SHIFT-1:0] stamp_bucket(input linha_t l);
        return l[BLOOM_INIT_POS-1 -: BITS_SHIFT];
    endfunction

    // Bucket 0 is the oldest, bucket NUM_BUCKETS-1 the newest.
    function automatic logic [BUCKET_SZ-1:0] get_bucket(input linha_t l, input int idx);
        return l[BLOOM_INIT_POS + idx*BUCKET_SZ +: BUCKET_SZ];
    endfunction

endpackage

// File: rtl/consulta_linha_if.sv
// Query, SRAM read port and result handshakes of the query engine.
interface consulta_linha_if;
    import consulta_linha_pkg::*;

    logic                       q_valid;
    logic                       q_ready;
    logic [SRAM_ADDR_WIDTH-1:0] q_addr;
    logic                       rd_req;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr;
    logic                       rd_ack;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       r_valid;
    logic                       r_ready;
    logic                       r_hit;
    logic [COUNT_W-1:0]         r_count;
    logic [BITS_SHIFT-1:0]      r_live;

    modport master (
        output q_valid, q_addr, rd_ack, rd_data, r_ready,
        input  q_ready, rd_req, rd_addr, r_valid, r_hit, r_count, r_live
    );

    modport slave (
        input  q_valid, q_addr, rd_ack, rd_data, r_ready,
        output q_ready, rd_req, rd_addr, r_valid, r_hit, r_count, r_live
    );

endinterface

// File: rtl/consulta_linha_calcula_idade.sv
// Virtual ageing of a line stamp against the current time base: produces the
// number of expired buckets and the mask of buckets still inside the window.
module calcula_idade
    import consulta_linha_pkg::*;
(
    input  logic [BITS_SHIFT-1:0]  data_bucket,
    input  logic [LOOP_W-1:0]      data_loop,
    input  logic [BITS_SHIFT-1:0]  cur_bucket,
    input  logic [LOOP_W-1:0]      cur_loop,
    output logic [BITS_SHIFT-1:0]  age,
    output logic [NUM_BUCKETS-1:0] live_mask
);

    logic [LOOP_W-1:0] loop_diff_s;
    logic [5:0]        age_raw_s;
    logic [5:0]        cur_ext_s;
    logic [5:0]        data_ext_s;

    // Age from stamp/time difference, clamped to [0, NUM_BUCKETS]
    always_comb begin
        loop_diff_s = cur_loop - data_loop;
        cur_ext_s   = {2'b00, cur_bucket};
        data_ext_s  = {2'b00, data_bucket};
        age_raw_s   = 6'd0;
        if (loop_diff_s == {LOOP_W{1'b0}}) begin
            if (cur_ext_s >= data_ext_s) begin
                age_raw_s = cur_ext_s - data_ext_s;
            end else begin
                age_raw_s = 6'd0;
            end
        end else if (loop_diff_s == LOOP_W'(1)) begin
            // A corrupt stamp above NUM_BUCKETS must not wrap into a huge age.
            if ((cur_ext_s + 6'(NUM_BUCKETS)) >= data_ext_s) begin
                age_raw_s = cur_ext_s + 6'(NUM_BUCKETS) - data_ext_s;
            end else begin
                age_raw_s = 6'd0;
            end
        end else begin
            age_raw_s = 6'(NUM_BUCKETS);
        end

        if (age_raw_s > 6'(NUM_BUCKETS)) begin
            age = BITS_SHIFT'(NUM_BUCKETS);
        end else begin
            age = age_raw_s[BITS_SHIFT-1:0];
        end
    end

    // The lowest 'age' buckets are expired
    always_comb begin
        live_mask = {NUM_BUCKETS{1'b0}};
        for (int i = 0; i < NUM_BUCKETS; i++) begin
            live_mask[i] = ({1'b0, BITS_SHIFT'(i)} >= {1'b0, age});
        end
    end

endmodule

// File: rtl/consulta_linha.sv
// Read-side query engine: fetches one bloom line, ages it virtually against the
// current time base and reports hit, live-count sum and live-bucket count.
module consulta_linha
    import consulta_linha_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BITS_SHIFT-1:0] cur_bucket,
    input  logic [LOOP_W-1:0]     cur_loop,
    consulta_linha_if.slave       bus
);

    estado_t                    state_q, state_d;
    logic                       q_ready_q, q_ready_d;
    logic                       rd_req_q, rd_req_d;
    logic                       r_valid_q, r_valid_d;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    linha_t                     line_q, line_d;
    logic [BITS_SHIFT-1:0]      cb_q, cb_d;
    logic [LOOP_W-1:0]          cl_q, cl_d;
    logic                       r_hit_q, r_hit_d;
    logic [COUNT_W-1:0]         r_count_q, r_count_d;
    logic [BITS_SHIFT-1:0]      r_live_q, r_live_d;

    logic [BITS_SHIFT-1:0]      age_s;
    logic [NUM_BUCKETS-1:0]     live_mask_s;
    logic [BUCKET_SZ-1:0]       bucket_s;
    logic [COUNT_W-1:0]         count_s;
    logic                       hit_s;

    calcula_idade u_idade (
        .data_bucket (stamp_bucket(line_q)),
        .data_loop   (stamp_loop(line_q)),
        .cur_bucket  (cb_q),
        .cur_loop    (cl_q),
        .age         (age_s),
        .live_mask   (live_mask_s)
    );

    // Adder tree over live buckets; dead buckets are masked, never cleared
    always_comb begin
        count_s  = {COUNT_W{1'b0}};
        hit_s    = 1'b0;
        bucket_s = {BUCKET_SZ{1'b0}};
        for (int i = 0; i < NUM_BUCKETS; i++) begin
            bucket_s = live_mask_s[i] ? get_bucket(line_q, i) : {BUCKET_SZ{1'b0}};
            count_s  = count_s + COUNT_W'(bucket_s);
            hit_s    = hit_s | (|bucket_s);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        line_d    = line_q;
        cb_d      = cb_q;
        cl_d      = cl_q;
        r_hit_d   = r_hit_q;
        r_count_d = r_count_q;
        r_live_d  = r_live_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.q_valid && q_ready_q) begin
                    rd_addr_d = bus.q_addr;
                    state_d   = ST_READ;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_READ: begin
                // Time base is sampled together with the data it ages
                if (bus.rd_ack) begin
                    line_d  = bus.rd_data;
                    cb_d    = cur_bucket;
                    cl_d    = cur_loop;
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_EVAL: begin
                r_hit_d   = hit_s;
                r_count_d = count_s;
                r_live_d  = BITS_SHIFT'(NUM_BUCKETS) - age_s;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (bus.r_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        q_ready_d = (state_d == ST_IDLE);
        rd_req_d  = (state_d == ST_READ);
        r_valid_d = (state_d == ST_RESP);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            q_ready_q <= 1'b0;
            rd_req_q  <= 1'b0;
            r_valid_q <= 1'b0;
            rd_addr_q <= {SRAM_ADDR_WIDTH{1'b0}};
            line_q    <= {DATA_WIDTH{1'b0}};
            cb_q      <= {BITS_SHIFT{1'b0}};
            cl_q      <= {LOOP_W{1'b0}};
            r_hit_q   <= 1'b0;
            r_count_q <= {COUNT_W{1'b0}};
            r_live_q  <= {BITS_SHIFT{1'b0}};
        end else begin
            state_q   <= state_d;
            q_ready_q <= q_ready_d;
            rd_req_q  <= rd_req_d;
            r_valid_q <= r_valid_d;
            rd_addr_q <= rd_addr_d;
            line_q    <= line_d;
            cb_q      <= cb_d;
            cl_q      <= cl_d;
            r_hit_q   <= r_hit_d;
            r_count_q <= r_count_d;
            r_live_q  <= r_live_d;
        end
    end

    assign bus.q_ready = q_ready_q;
    assign bus.rd_req  = rd_req_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.r_valid = r_valid_q;
    assign bus.r_hit   = r_hit_q;
    assign bus.r_count = r_count_q;
    assign bus.r_live  = r_live_q;

endmodule

// File: doc/consulta_linha.md
# consulta_linha

Read-side query engine for the time-windowed bloom table whose lines are aged and written back by the line-update path. It accepts a lookup address, fetches the line from SRAM through a req/ack read port, and virtually ages it against the current time base (`cur_bucket`, `cur_loop`). It then reports whether the key is present within the window, plus the live-bucket count sum. It never writes memory; stale buckets are masked, not cleared.

## Interface
- `DATA_WIDTH`, 72: SRAM line width.
- `NUM_BUCKETS`, 14: buckets per line.
- `BUCKET_SZ`, 4: bits per bucket counter.
- `BITS_SHIFT`, 4: width of the bucket stamp field.
- `BLOOM_INIT_POS`, 16: LSB of the bloom field; `[BLOOM_INIT_POS-BITS_SHIFT-1:0]` is the loop stamp, and `[BLOOM_INIT_POS-1:BLOOM_INIT_POS-BITS_SHIFT]` is the bucket stamp.
- `SRAM_ADDR_WIDTH`, 19: line address width.
- `COUNT_W`, 8: width of the count sum; it must hold `NUM_BUCKETS*(2^BUCKET_SZ-1)`.
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `q_valid`, in, 1: query request.
- `q_addr`, in, SRAM_ADDR_WIDTH: line to query.
- `q_ready`, out, 1: engine idle; a query is accepted on `q_valid & q_ready`.
- `cur_bucket`, in, BITS_SHIFT: current time-base bucket.
- `cur_loop`, in, BLOOM_INIT_POS-BITS_SHIFT: current time-base loop.
- `rd_req`, out, 1: SRAM read request, held until `rd_ack`.
- `rd_addr`, out, SRAM_ADDR_WIDTH: read address, stable while `rd_req` is asserted.
- `rd_ack`, in, 1: read data valid this cycle.
- `rd_data`, in, DATA_WIDTH: line contents.
- `r_valid`, out, 1: result valid, held until `r_ready`.
- `r_ready`, in, 1: result consumer ready.
- `r_hit`, out, 1: at least one live bucket is nonzero.
- `r_count`, out, COUNT_W: sum of live bucket counters.
- `r_live`, out, BITS_SHIFT: number of live buckets (`NUM_BUCKETS - age`).

## Operation
- **FSM states:** IDLE → READ → EVAL → RESP → IDLE.
- **IDLE**
  - `q_ready`=1.
  - On accept, latch `q_addr` and go to READ.
- **READ**
  - `rd_req`=1, `rd_addr`=latched address.
  - On `rd_ack`, capture `rd_data`, `cur_bucket` and `cur_loop` in the same cycle, then go to EVAL.
- **Age computation** (captured values; `loop_diff = cur_loop - data_loop` modulo `2^(BLOOM_INIT_POS-BITS_SHIFT)`):
  - `loop_diff`=0: age = `cur_bucket - data_bucket` if `cur_bucket >= data_bucket`, else 0 (line is newer than the sample).
  - `loop_diff`=1: age = `NUM_BUCKETS - data_bucket + cur_bucket`.
  - Any other `loop_diff`: age = `NUM_BUCKETS`.
  - Age saturates at `NUM_BUCKETS`.
- **Liveness:** the bloom field holds the newest bucket at the top (index `NUM_BUCKETS-1`). The lowest `age` buckets are dead; the rest are live.
- **EVAL**
  - Register `r_hit`, `r_count` and `r_live` from the live mask and the adder tree.
  - Go to RESP.
- **RESP**
  - `r_valid`=1 with stable outputs.
  - On `r_ready`, go to IDLE.
- **Line never written** (all zeros): treated normally, giving `r_hit`=0 and `r_count`=0.
- **Simultaneous `r_ready` and new `q_valid`:** the new query is not accepted until the following IDLE cycle.

## Timing
- **Reset values:** `q_ready`=0 in the reset cycle, then 1; `rd_req`=0; `rd_addr`=0; `r_valid`=0; `r_hit`=0; `r_count`=0; `r_live`=0. FSM resets to IDLE.
- **Latency:**
  - Cycle 0: accept.
  - Cycle 1: `rd_req` rises.
  - Cycle A: `rd_ack` arrives.
  - Cycle A+1: EVAL.
  - Cycle A+2: `r_valid`=1.
  - Minimum accept-to-result is 3 cycles when `rd_ack` arrives in cycle 1.
- **Throughput:** one query in flight at a time; `q_ready`=0 from the accept cycle+1 until the return to IDLE.
- **`rd_ack` outside READ:** ignored.
- **Reset mid-operation:** abandon the read; `rd_req` drops on the next edge; return to IDLE; no result is emitted.

## Structure
- **Shared header:** line field positions (loop, bucket and bloom slices), `NUM_BUCKETS` and `BUCKET_SZ` defaults, used by both this block and the line-update path.
- **Sub-module `calcula_idade`:** combinational age computation plus live mask, with stamp inputs and current-time inputs. The update path will later reuse it.

## Test plan
- Line with stamp (bucket 3, loop 5), all buckets =1; cur = (3, 5) → `r_live`=14, `r_count`=14, `r_hit`=1.
- Same line; cur = (5, 5) → `r_live`=12, `r_count`=12.
- Stamp (12, 5); cur = (2, 6) → age 4, `r_live`=10. Only the top buckets set → `r_hit`=1; only the bottom 4 set → `r_hit`=0, `r_count`=0.
- Stamp (0, 5); cur = (0, 7) → `r_live`=0, `r_hit`=0. Loop wrap: stamp loop `0xFFF`, cur loop 0, bucket 13 vs 1 → age 2.
- `rd_ack` delayed 5 cycles with `r_ready` low for 3 cycles:
  - `rd_addr` stays stable;
  - `r_valid` holds with stable outputs;
  - `q_ready`=0 throughout.
- `reset` asserted while in READ → `rd_req`=0 next cycle, `r_valid` never rises, the next query completes correctly.
